// File: rtl/pipe_stage_chain.sv
// DEPTH-stage register chain carrying data plus a valid tag, with global stall and per-stage flush.
// Optional PIPE_STAGE_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter on stall_cnt.
module pipe_stage_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DEPTH-1:0] flush,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [15:0]      stall_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][WIDTH-1:0] data_prev;
    logic [DEPTH-1:0]            valid_prev;

    // Source for each stage when the chain advances: the input for stage 0,
    // otherwise the previous stage's pre-edge contents.
    always_comb begin
        data_prev     = '0;
        valid_prev    = '0;
        data_prev[0]  = in;
        valid_prev[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            data_prev[i]  = data[i-1];
            valid_prev[i] = valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i]  <= RESET_VAL;
                valid[i] <= 1'b0;
            end
        end else begin
            // Flush overrides stall; a flushed stage still feeds its old contents forward.
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[i]) begin
                    data[i]  <= FLUSH_VAL;
                    valid[i] <= 1'b0;
                end else if (en) begin
                    data[i]  <= data_prev[i];
                    valid[i] <= valid_prev[i];
                end
            end
        end
    end

    assign out       = data[DEPTH-1];
    assign out_valid = valid[DEPTH-1];

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= 16'h0000;
        else if (!en && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomized scoreboard bench for pipe_stage_chain (DEPTH=3) against a list-shift reference model.
// Honours PIPE_STAGE_STALL_CNT_EN for the expected stall counter.
module tb_pipe_stage_chain;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 3;
    localparam logic [31:0] RVAL  = 32'hDEAD_0000;
    localparam logic [31:0] FVAL  = 32'h0000_0013;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic [DEPTH-1:0] flush = '0;
    logic [WIDTH-1:0] in = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [15:0]      stall_cnt;

    pipe_stage_chain #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL), .FLUSH_VAL(FVAL)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in(in),
        .in_valid(in_valid), .out(out), .out_valid(out_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sb[$];

    // Reference: pipeline contents as a list, index 0 = newest entry.
    logic [31:0] m_d[DEPTH];
    logic        m_v[DEPTH];
    int          m_cnt = 0;

    task automatic step(input logic r, input logic e, input logic [DEPTH-1:0] f,
                        input logic [31:0] d, input logic v, input bit push);
        logic [31:0] nd[DEPTH];
        logic        nv[DEPTH];
        exp_t        x;
        @(negedge clk);
        reset = r; en = e; flush = f; in = d; in_valid = v;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin nd[i] = RVAL; nv[i] = 1'b0; end
            m_cnt = 0;
        end else begin
            if (e) begin
                nd[0] = d; nv[0] = v;
                for (int i = 1; i < DEPTH; i++) begin nd[i] = m_d[i-1]; nv[i] = m_v[i-1]; end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin nd[i] = m_d[i]; nv[i] = m_v[i]; end
                if (m_cnt < 65535) m_cnt++;
            end
            for (int i = 0; i < DEPTH; i++)
                if (f[i]) begin nd[i] = FVAL; nv[i] = 1'b0; end
        end
        for (int i = 0; i < DEPTH; i++) begin m_d[i] = nd[i]; m_v[i] = nv[i]; end
        if (push) begin
            x.d = m_d[DEPTH-1];
            x.v = m_v[DEPTH-1];
`ifdef PIPE_STAGE_STALL_CNT_EN
            x.cnt = 16'(m_cnt);
`else
            x.cnt = 16'h0000;
`endif
            x.cyc = cyc;
            sb.push_back(x);
        end
    endtask

    exp_t e_mon;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            checks += 3;
            if (out !== e_mon.d) begin
                errors++;
                $display("FAIL out cyc=%0d got %h exp %h", e_mon.cyc, out, e_mon.d);
            end
            if (out_valid !== e_mon.v) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got %b exp %b", e_mon.cyc, out_valid, e_mon.v);
            end
            if (stall_cnt !== e_mon.cnt) begin
                errors++;
                $display("FAIL stall_cnt cyc=%0d got %h exp %h", e_mon.cyc, stall_cnt, e_mon.cnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_d[i] = '0; m_v[i] = 1'b0; end
        // Reset with live input, then two idle edges keep the reset value at out.
        step(1, 1, 3'b000, 32'h1234, 1, 1);
        step(0, 1, 3'b000, 32'h5555, 0, 1);
        step(0, 1, 3'b000, 32'h6666, 0, 1);
        // Back-to-back stream.
        for (int i = 1; i <= 4; i++) step(0, 1, 3'b000, 32'(i), 1, 1);
        // Stall two edges with entries in flight.
        step(0, 0, 3'b000, 32'hAAAA, 1, 1);
        step(0, 0, 3'b000, 32'hBBBB, 1, 1);
        for (int i = 5; i <= 7; i++) step(0, 1, 3'b000, 32'(i), 1, 1);
        // Flush under stall, then advance.
        step(0, 0, 3'b010, 32'h0, 0, 1);
        step(0, 1, 3'b000, 32'h8, 1, 1);
        step(0, 1, 3'b000, 32'h9, 1, 1);
        // Flush stage 0 while advancing.
        step(0, 1, 3'b001, 32'hCAFE, 1, 1);
        step(0, 1, 3'b000, 32'hA, 1, 1);
        step(0, 1, 3'b000, 32'hB, 1, 1);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, e, v;
            logic [DEPTH-1:0] f;
            r = ($urandom_range(0, 63) == 0);
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 4) == 0) ? DEPTH'($urandom_range(1, 7)) : '0;
            v = $urandom_range(0, 1) == 1;
            step(r, e, f, $urandom, v, 1);
        end
        // Long stall drives the counter into saturation; only the final state is checked.
        for (int i = 0; i < 70000; i++) step(0, 0, 3'b000, $urandom, 1, i == 69999);
        step(0, 0, 3'b000, 32'h1, 1, 1);
        step(1, 0, 3'b000, 32'h2, 1, 1);
        step(0, 1, 3'b000, 32'h3, 1, 1);
        step(0, 1, 3'b000, 32'h4, 1, 1);
        step(0, 1, 3'b000, 32'h5, 1, 1);
        begin
            int n = 0;
            while (sb.size() > 0 && n < 10) begin @(negedge clk); n++; end
            @(posedge clk);
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending exp 0", sb.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
